// File: rtl/pipe_pkg.sv
// Shared definitions for the ready/valid pipeline register slice.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [31:0] NOP_DEFAULT = '0;

endpackage

// File: rtl/pipe_entry.sv
// Enable-loaded instruction + data register; reset loads RST_IR and zero data.
module pipe_entry #(
  parameter int unsigned W  = 32,
  parameter int unsigned NF = 2,
  parameter int unsigned IW = 32,
  parameter logic [IW-1:0] RST_IR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [IW-1:0]       d_ir,
  input  logic [NF*W-1:0]     d_data,
  output logic [IW-1:0]       q_ir,
  output logic [NF*W-1:0]     q_data
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_ir   <= RST_IR;
      q_data <= '0;
    end else if (en) begin
      q_ir   <= d_ir;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_reg_rv.sv
// Two-entry ready/valid pipeline register (output + skid) with registered
// in_ready, bubble insertion on drain, and synchronous flush.
module pipe_reg_rv
  import pipe_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned NF = 2,
  parameter int unsigned IW = 32,
  parameter logic [IW-1:0] NOP = IW'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     in_IR,
  input  logic [NF*W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW-1:0]     out_IR,
  output logic [NF*W-1:0]   out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t         state, state_nxt;
  logic                in_ready_q;
  logic                in_fire, out_fire;
  logic                out_en, skid_en;
  logic [IW-1:0]       out_d_ir, skid_ir;
  logic [NF*W-1:0]     out_d_data, skid_data;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt  = state;
    out_en     = 1'b0;
    skid_en    = 1'b0;
    out_d_ir   = in_IR;
    out_d_data = in_data;
    if (flush) begin
      // Flush wins over any same-cycle fire; a coinciding out-fire is simply consumed.
      state_nxt  = EMPTY;
      out_en     = 1'b1;
      out_d_ir   = NOP;
      out_d_data = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            out_en    = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_en = 1'b1;
          end else if (in_fire) begin
            skid_en   = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            out_en     = 1'b1;
            out_d_ir   = NOP;
            out_d_data = '0;
            state_nxt  = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            out_en     = 1'b1;
            out_d_ir   = skid_ir;
            out_d_data = skid_data;
            state_nxt  = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  pipe_entry #(.W(W), .NF(NF), .IW(IW), .RST_IR(NOP)) u_out (
    .clk    (clk),
    .reset  (reset),
    .en     (out_en),
    .d_ir   (out_d_ir),
    .d_data (out_d_data),
    .q_ir   (out_IR),
    .q_data (out_data)
  );

  pipe_entry #(.W(W), .NF(NF), .IW(IW), .RST_IR('0)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .en     (skid_en),
    .d_ir   (in_IR),
    .d_data (in_data),
    .q_ir   (skid_ir),
    .q_data (skid_data)
  );

endmodule

// File: tb/tb_pipe_reg_rv.sv
// Bench for pipe_reg_rv: directed scenarios plus random handshaking against a
// queue-based reference of the two-entry stage.
module tb_pipe_reg_rv;

  localparam int unsigned W  = 32;
  localparam int unsigned NF = 2;
  localparam int unsigned IW = 32;
  localparam logic [IW-1:0] NOP = '0;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [IW-1:0]     in_IR, out_IR;
  logic [NF*W-1:0]   in_data, out_data;
  logic [1:0]        occupancy;

  typedef struct {
    logic [IW-1:0]   ir;
    logic [NF*W-1:0] data;
  } ent_t;

  ent_t q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_reg_rv #(.W(W), .NF(NF), .IW(IW), .NOP(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_IR     (in_IR),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_IR    (out_IR),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_model();
    int n;
    n = q.size();
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("in_ready",  64'(in_ready),  64'(n < 2));
    chk("occupancy", 64'(occupancy), 64'(n));
    chk("out_IR",    64'(out_IR),    (n != 0) ? 64'(q[0].ir)   : 64'(NOP));
    chk("out_data",  64'(out_data),  (n != 0) ? 64'(q[0].data) : 64'd0);
  endtask

  // Apply one cycle of inputs, advance the reference at the edge, then check.
  task automatic cycle(input logic rst, input logic fl, input logic v,
                       input logic [IW-1:0] ir, input logic [NF*W-1:0] d,
                       input logic ordy);
    bit in_f, out_f;
    ent_t e;
    reset = rst; flush = fl; in_valid = v; in_IR = ir; in_data = d; out_ready = ordy;
    in_f  = v && (q.size() < 2);
    out_f = ordy && (q.size() != 0);
    @(posedge clk);
    if (!rst || fl) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) begin
        e.ir = ir; e.data = d;
        q.push_back(e);
      end
    end
    #1;
    check_model();
  endtask

  initial begin
    int emitted;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_IR = '0; in_data = '0;

    // Reset for two cycles
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_IR",    64'(out_IR),    64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);

    // Basic transfer, field1=-1 field0=34
    cycle(1'b1, 1'b0, 1'b1, 32'd100, {32'hFFFF_FFFF, 32'd34}, 1'b1);
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_IR",    64'(out_IR),    64'd100);
    chk("basic_f0",    64'(out_data[0 +: W]), 64'd34);
    chk("basic_f1",    64'(out_data[W +: W]), 64'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("basic_drain_IR", 64'(out_IR), 64'(NOP));

    // Skid case
    cycle(1'b1, 1'b0, 1'b1, 32'd1, 64'h11, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'd2, 64'h22, 1'b0);
    chk("skid_occ",   64'(occupancy), 64'd2);
    chk("skid_rdy",   64'(in_ready),  64'd0);
    chk("skid_IR1",   64'(out_IR),    64'd1);
    cycle(1'b1, 1'b0, 1'b1, 32'd77, 64'h77, 1'b0); // ignored while FULL
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("skid_IR2",   64'(out_IR),    64'd2);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("skid_empty", 64'(out_valid), 64'd0);
    chk("skid_nop",   64'(out_IR),    64'(NOP));

    // Streaming 10..17 back to back
    emitted = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (i < 8) cycle(1'b1, 1'b0, 1'b1, IW'(10 + i), 64'(i * 3), 1'b1);
      else       cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
      if (i < 8 && out_valid && out_IR == IW'(10 + i)) emitted++;
    end
    chk("stream_count", 64'(emitted), 64'd8);

    // Flush when FULL, with a concurrent in_valid IR=99
    cycle(1'b1, 1'b0, 1'b1, 32'd5, 64'h5, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'd6, 64'h6, 1'b0);
    chk("flush_pre_occ", 64'(occupancy), 64'd2);
    cycle(1'b1, 1'b1, 1'b1, 32'd99, 64'h99, 1'b0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_IR",  64'(out_IR),    64'(NOP));
    chk("flush_rdy", 64'(in_ready),  64'd1);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("flush_no99", 64'(out_IR == 32'd99), 64'd0);

    // Reset mid-stall, then normal acceptance
    cycle(1'b1, 1'b0, 1'b1, 32'd7, 64'h7, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'd8, 64'h8, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd9, 64'h9, 1'b1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_rdy",   64'(in_ready),  64'd1);
    chk("midrst_occ",   64'(occupancy), 64'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'd42, 64'h4242, 1'b0);
    chk("midrst_accept", 64'(out_IR), 64'd42);

    // Random handshaking with occasional flush and reset
    for (int unsigned i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 24) == 0),
            1'($urandom),
            $urandom,
            {$urandom, $urandom},
            ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
